// File: rtl/qos_fuente.sv
// Transmit-side traffic source for the qos flow-control interface.
// Sends a programmed number of words per virtual channel, round-robin, honouring pausa/continuar.
module qos_fuente #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int BUF_WIDTH      = 3,
    parameter int MAX_WORDS      = 15,
    localparam int CNT_W         = $clog2(MAX_WORDS + 1),
    localparam int VC_W          = $clog2(QUEUE_QUANTITY),
    localparam int TOT_W         = CNT_W + VC_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enb,
    input  logic                        iniciar,
    input  logic [QUEUE_QUANTITY*CNT_W-1:0] cantidades,
    input  logic [QUEUE_QUANTITY-1:0]   pausa,
    input  logic [QUEUE_QUANTITY-1:0]   continuar,
    input  logic [QUEUE_QUANTITY-1:0]   error_full,
    output logic [VC_W-1:0]             vc_id,
    output logic [BUF_WIDTH:0]          data_word,
    output logic                        valido,
    output logic                        terminado,
    output logic                        error_tx,
    output logic [VC_W-1:0]             error_vc,
    output logic [TOT_W-1:0]            total_enviados
);

    typedef enum logic [2:0] {REPOSO, ENVIANDO, ESPERA, FIN, ERROR} estado_t;

    estado_t state, state_next;

    logic [CNT_W-1:0]          restante [QUEUE_QUANTITY];
    logic [BUF_WIDTH:0]        seq      [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0] bloqueado, bloqueado_next;
    logic [QUEUE_QUANTITY-1:0] elegible, pendiente;
    logic [VC_W-1:0]           puntero;
    logic                      iniciar_q;
    logic                      arranque;
    logic                      valido_q;
    logic                      cant_cero;
    logic                      found;
    logic [VC_W-1:0]           sel, sel_next, idx, err_idx;
    logic                      do_load, do_send, to_fin, to_err;

    assign arranque = iniciar & ~iniciar_q;
    assign valido   = valido_q & enb;
    assign sel_next = (sel == VC_W'(QUEUE_QUANTITY - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        cant_cero = 1'b1;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            pendiente[i] = (restante[i] != '0);
            elegible[i]  = pendiente[i] & ~bloqueado[i] & ~pausa[i];
            if (cantidades[i*CNT_W +: CNT_W] != '0)
                cant_cero = 1'b0;
        end
    end

    // Round-robin pick starting at puntero; lowest set error bit for error_vc.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        idx     = '0;
        err_idx = '0;
        for (int k = 0; k < QUEUE_QUANTITY; k++) begin
            idx = VC_W'((int'(puntero) + k) % QUEUE_QUANTITY);
            if (!found && elegible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        for (int i = QUEUE_QUANTITY - 1; i >= 0; i--) begin
            if (error_full[i])
                err_idx = VC_W'(i);
        end
    end

    // A start clears the block mask, but a pausa in the same cycle still takes effect.
    always_comb begin
        bloqueado_next = do_load ? '0 : bloqueado;
        bloqueado_next = (bloqueado_next & ~(continuar & ~pausa)) | pausa;
    end

    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_send    = 1'b0;
        to_fin     = 1'b0;
        to_err     = 1'b0;
        case (state)
            REPOSO, FIN: begin
                if (arranque) begin
                    do_load    = 1'b1;
                    state_next = cant_cero ? FIN : ENVIANDO;
                end
            end
            ENVIANDO: begin
                if (|error_full) begin
                    to_err     = 1'b1;
                    state_next = ERROR;
                end else if (!(|pendiente)) begin
                    to_fin     = 1'b1;
                    state_next = FIN;
                end else if (found) begin
                    do_send = 1'b1;
                end else begin
                    state_next = ESPERA;
                end
            end
            ESPERA: begin
                if (|error_full) begin
                    to_err     = 1'b1;
                    state_next = ERROR;
                end else if (|elegible) begin
                    state_next = ENVIANDO;
                end
            end
            ERROR: state_next = ERROR;
            default: state_next = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REPOSO;
            bloqueado      <= '0;
            puntero        <= '0;
            iniciar_q      <= 1'b0;
            valido_q       <= 1'b0;
            vc_id          <= '0;
            data_word      <= '0;
            terminado      <= 1'b0;
            error_tx       <= 1'b0;
            error_vc       <= '0;
            total_enviados <= '0;
            for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                restante[i] <= '0;
                seq[i]      <= '0;
            end
        end else if (enb) begin
            state     <= state_next;
            iniciar_q <= iniciar;
            valido_q  <= do_send;
            if (state != ERROR)
                bloqueado <= bloqueado_next;
            if (do_load) begin
                puntero        <= '0;
                total_enviados <= '0;
                terminado      <= cant_cero;
                for (int i = 0; i < QUEUE_QUANTITY; i++) begin
                    restante[i] <= cantidades[i*CNT_W +: CNT_W];
                    seq[i]      <= '0;
                end
            end
            if (do_send) begin
                vc_id          <= sel;
                data_word      <= seq[sel];
                seq[sel]       <= seq[sel] + 1'b1;
                restante[sel]  <= restante[sel] - 1'b1;
                total_enviados <= total_enviados + 1'b1;
                puntero        <= sel_next;
            end
            if (to_fin)
                terminado <= 1'b1;
            if (to_err) begin
                error_tx <= 1'b1;
                error_vc <= err_idx;
            end
        end
    end

endmodule

// File: doc/qos_fuente.md
Name: qos_fuente

Overview:
- Traffic source at the transmit end of the qos flow-control interface.
- After a start edge, sends a programmed number of words into each virtual channel (VC) as (vc_id, data_word, valido) triples, interleaving VCs round-robin.
- Honours per-VC pausa/continuar back-pressure and stops on any error_full.
- Used in the integration bench and as a front-end generator ahead of qos.

Parameters:
- QUEUE_QUANTITY, 4, number of VCs.
- BUF_WIDTH, 3, data_word is BUF_WIDTH+1 bits wide.
- MAX_WORDS, 15, maximum words per VC; CNT_W = $clog2(MAX_WORDS+1).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- enb  in  1  global enable; when low, all state is frozen and valido is forced to 0.
- iniciar  in  1  level input; a rising edge starts a run.
- cantidades  in  QUEUE_QUANTITY*CNT_W  words to send per VC; VC i occupies bits [i*CNT_W +: CNT_W].
- pausa  in  QUEUE_QUANTITY  per-VC pause request.
- continuar  in  QUEUE_QUANTITY  per-VC resume request.
- error_full  in  QUEUE_QUANTITY  per-VC overflow indication.
- vc_id  out  $clog2(QUEUE_QUANTITY)  channel of the current word.
- data_word  out  BUF_WIDTH+1  payload.
- valido  out  1  word valid; one word per cycle.
- terminado  out  1  run complete.
- error_tx  out  1  run aborted.
- error_vc  out  $clog2(QUEUE_QUANTITY)  lowest VC whose error_full bit was set at abort.
- total_enviados  out  CNT_W+$clog2(QUEUE_QUANTITY)  words sent in the current run.

Behaviour:
- Reset value of every output is 0. Internal state on reset:
  - state=REPOSO
  - restante[i]=0, seq[i]=0
  - bloqueado=0
  - puntero=0
  - iniciar_q=0
- arranque = iniciar & ~iniciar_q, where iniciar_q is registered every cycle with enb high.
- States: REPOSO, ENVIANDO, ESPERA, FIN, ERROR.
- REPOSO and FIN:
  - On arranque: restante[i] <= cantidades[i]; seq <= 0; puntero <= 0; bloqueado <= 0; total_enviados <= 0; terminado <= 0.
  - Next state is ENVIANDO, or FIN if every cantidades[i]==0. FIN is entered the next cycle and terminado=1.
- Eligibility: elegible[i] = (restante[i]!=0) & ~bloqueado[i] & ~pausa[i]. A live pausa blocks the same cycle.
- ENVIANDO, each cycle:
  - sel = first elegible index scanning puntero, puntero+1, ... modulo QUEUE_QUANTITY.
  - If sel is found, registered outputs next edge: valido<=1, vc_id<=sel, data_word<=seq[sel].
  - Also on that edge: seq[sel]<=seq[sel]+1 (wraps mod 2^(BUF_WIDTH+1)); restante[sel] decrements; total_enviados increments; puntero<=sel+1 mod QUEUE_QUANTITY.
  - Latency is 1 cycle from the decision to the word on the outputs.
  - If no VC is elegible but some restante!=0: valido<=0 and state goes to ESPERA.
  - If all restante==0 after the last send: state goes to FIN, terminado<=1, valido<=0.
- ESPERA:
  - valido=0.
  - Goes to ENVIANDO in the cycle any elegible bit is 1; the first word is issued from ENVIANDO the next cycle.
- Blocking:
  - bloqueado[i] <= 1 when pausa[i]=1.
  - bloqueado[i] <= 0 when continuar[i]=1 & pausa[i]=0.
  - Simultaneous pausa and continuar: pausa wins.
  - Blocking is tracked in every state except ERROR.
- Error:
  - Any error_full bit high while in ENVIANDO or ESPERA: state goes to ERROR, valido<=0, error_tx<=1, error_vc <= lowest set index.
  - error_full takes priority over a send in the same cycle; that word is not issued and not counted.
  - ERROR is left only via rst; arranque is ignored in ERROR.
- enb=0: no register changes except that valido is forced to 0 on the output. Counters, seq and the state machine hold.
- rst mid-run: returns everything to reset values on the next edge; any in-flight word is dropped.
- terminado stays high in FIN until the next arranque.

Test Plan:
- cantidades={3,2,1,0} (VC3..VC0: VC0=0, VC1=1, VC2=2, VC3=3), no pausa, iniciar rising -> valido words (vc,data):
  - (1,0), (2,0), (3,0), (2,1), (3,1), (3,2)
  - then terminado=1 and total_enviados=6.
- All four VCs set to 4, pausa[2]=1 held 5 cycles then continuar[2] pulse -> no vc_id=2 words while blocked; VC2 resumes with data 0..3 in order; total_enviados=16.
- All cantidades=0, iniciar edge -> no valido; terminado=1 one cycle later.
- VC0=15, others 0, pausa[0] and continuar[0] high in the same cycle -> stays blocked (pausa wins), state ESPERA. After continuar alone, 15 words with data 0..14.
- Mid-run error_full=4'b1010 -> valido=0 next edge, error_tx=1, error_vc=1. A new iniciar edge has no effect; rst clears all outputs to 0.
- enb=0 for 3 cycles mid-run -> valido=0 and counts frozen; resumes with the same next (vc,data) it would have sent.
